// File: rtl/mdu_iterative_if.sv
// EX <-> multiply/divide unit request/response bundle.
// EX drives the request side (master); the MDU drives status and HI/LO (slave).
interface mdu_iterative_if #(
    parameter int XLEN = 32
) ();
    logic            start;
    logic [2:0]      op;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;

    modport master (
        output start, op, rs_data, rt_data, flush,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, flush,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_iterative.sv
// Multi-cycle MULT/MULTU/DIV/DIVU/MTHI/MTLO unit that owns the architectural HI/LO registers.
// Define MDU_FAST_MUL_EN to replace the 32-cycle shift-add multiply with a single-cycle multiply.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic           clk,
    input  logic           rst,
    mdu_iterative_if.slave bus
);

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_FIX
    } state_e;

    state_e state_q, state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [2*XLEN-1:0] acc_q;     // {partial product, remaining multiplier bits}
    logic [XLEN-1:0]   mcand_q;   // multiplicand or divisor magnitude
    logic [XLEN-1:0]   rem_q;
    logic [XLEN-1:0]   quo_q;     // dividend bits shift out as quotient bits shift in
    logic              is_div_q;
    logic              neg_res_q;
    logic              neg_rem_q;
    logic              dbz_q;
    logic [XLEN-1:0]   hi_q;
    logic [XLEN-1:0]   lo_q;
    logic              done_q;

    op_e             op;
    logic            op_signed;
    logic [XLEN-1:0] abs_a;
    logic [XLEN-1:0] abs_b;
    logic            neg_ab;

    logic accept_mul;
    logic accept_div;
    logic move_hi;
    logic move_lo;
    logic commit;
    logic last_iter;

    assign op        = op_e'(bus.op);
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign abs_a     = (op_signed && bus.rs_data[XLEN-1]) ? -bus.rs_data : bus.rs_data;
    assign abs_b     = (op_signed && bus.rt_data[XLEN-1]) ? -bus.rt_data : bus.rt_data;
    assign neg_ab    = op_signed && (bus.rs_data[XLEN-1] ^ bus.rt_data[XLEN-1]);
    assign last_iter = (cnt_q == CNT_W'(XLEN - 1));

    // NOTE: state register only; all next-state logic lives in the always_comb below.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every output of this block is given a default first so no latch is inferred.
    always_comb begin
        state_d    = state_q;
        accept_mul = 1'b0;
        accept_div = 1'b0;
        move_hi    = 1'b0;
        move_lo    = 1'b0;
        commit     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            accept_mul = 1'b1;
`ifdef MDU_FAST_MUL_EN
                            state_d    = S_FIX;
`else
                            state_d    = S_MUL;
`endif
                        end
                        OP_DIV, OP_DIVU: begin
                            accept_div = 1'b1;
                            state_d    = S_DIV;
                        end
                        OP_MTHI: move_hi = 1'b1;
                        OP_MTLO: move_lo = 1'b1;
                        default: ;
                    endcase
                end
            end
            S_MUL, S_DIV: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else if (last_iter) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                commit  = !bus.flush;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Shift-add step: add the multiplicand when the current multiplier bit is set.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, mcand_q} & {(XLEN+1){acc_q[0]}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

    // Restoring step on the 33-bit shifted partial remainder.
    logic [XLEN:0]   div_shift;
    logic            div_ok;
    logic [XLEN-1:0] rem_next;
    assign div_shift = {rem_q, quo_q[XLEN-1]};
    assign div_ok    = (div_shift >= {1'b0, mcand_q});
    assign rem_next  = div_ok ? (div_shift[XLEN-1:0] - mcand_q) : div_shift[XLEN-1:0];

    logic [2*XLEN-1:0] fix_prod;
    logic [XLEN-1:0]   fix_quo;
    logic [XLEN-1:0]   fix_rem;
    assign fix_prod = neg_res_q ? -acc_q : acc_q;
    assign fix_quo  = dbz_q ? '1 : (neg_res_q ? -quo_q : quo_q);
    assign fix_rem  = neg_rem_q ? -rem_q : rem_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: working registers are cleared too, so an aborted op leaves nothing stale behind.
            cnt_q     <= '0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dbz_q     <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;

            if (move_hi) begin
                hi_q   <= bus.rs_data;
                done_q <= 1'b1;
            end
            if (move_lo) begin
                lo_q   <= bus.rs_data;
                done_q <= 1'b1;
            end

            if (accept_mul) begin
`ifdef MDU_FAST_MUL_EN
                acc_q     <= {{XLEN{1'b0}}, abs_a} * {{XLEN{1'b0}}, abs_b};
`else
                acc_q     <= {{XLEN{1'b0}}, abs_b};
`endif
                mcand_q   <= abs_a;
                cnt_q     <= '0;
                is_div_q  <= 1'b0;
                neg_res_q <= neg_ab;
                neg_rem_q <= 1'b0;
                dbz_q     <= 1'b0;
            end

            if (accept_div) begin
                rem_q     <= '0;
                quo_q     <= abs_a;
                mcand_q   <= abs_b;
                cnt_q     <= '0;
                is_div_q  <= 1'b1;
                neg_res_q <= neg_ab;
                neg_rem_q <= op_signed && bus.rs_data[XLEN-1];
                dbz_q     <= (bus.rt_data == '0);
            end

            if (state_q == S_MUL) begin
                acc_q <= mul_next;
                cnt_q <= cnt_q + 1'b1;
            end

            if (state_q == S_DIV) begin
                rem_q <= rem_next;
                quo_q <= {quo_q[XLEN-2:0], div_ok};
                cnt_q <= cnt_q + 1'b1;
            end

            if (commit) begin
                done_q <= 1'b1;
                if (is_div_q) begin
                    hi_q <= fix_rem;
                    lo_q <= fix_quo;
                end else begin
                    hi_q <= fix_prod[2*XLEN-1:XLEN];
                    lo_q <= fix_prod[XLEN-1:0];
                end
            end
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mdu_iterative.sv
// Directed bench for mdu_iterative: arithmetic results, latency, busy window, moves, flush and reset.
// Build with MDU_FAST_MUL_EN defined to check the single-cycle multiply latency.
module tb_mdu_iterative;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_DIV   = 3'd2;
    localparam logic [2:0] OP_DIVU  = 3'd3;
    localparam logic [2:0] OP_MTHI  = 3'd4;
    localparam logic [2:0] OP_MTLO  = 3'd5;
    localparam logic [2:0] OP_RSVD  = 3'd6;

`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 2;
`else
    localparam int MUL_LAT = 34;
`endif
    localparam int DIV_LAT = 34;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    mdu_iterative_if bus ();

    mdu_iterative dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int tests  = 0;
    int failed = 0;
    int lat;
    int bcnt;
    int dcnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            failed++;
            $error("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        bus.start   = 1'b1;
        bus.op      = o;
        bus.rs_data = a;
        bus.rt_data = b;
        step();
        bus.start = 1'b0;
        lat  = 1;
        bcnt = 0;
    endtask

    task automatic wait_done();
        while (bus.done !== 1'b1 && lat < 200) begin
            if (bus.busy === 1'b1) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic run_check(input string tag, input logic [2:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input int exp_lat);
        issue(o, a, b);
        wait_done();
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_busycyc"}, 32'(bcnt), 32'(exp_lat - 1));
        check({tag, "_hi"}, bus.hi, exp_hi);
        check({tag, "_lo"}, bus.lo, exp_lo);
        check({tag, "_busy_at_done"}, 32'(bus.busy), 32'd0);
        step();
        check({tag, "_done_drop"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.op      = OP_MULT;
        bus.rs_data = '0;
        bus.rt_data = '0;
        step();
        step();
        check("rst_hi", bus.hi, 32'h0);
        check("rst_lo", bus.lo, 32'h0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        rst = 1'b0;
        step();

        // Arithmetic results, latency and busy window.
        run_check("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT);
        run_check("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB, MUL_LAT);
        run_check("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT);
        run_check("div_negb",  OP_DIV,   32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, DIV_LAT);
        run_check("divu",      OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        DIV_LAT);
        run_check("divu_z",    OP_DIVU,  32'h1234_5678, 32'h0,         32'h1234_5678, 32'hFFFF_FFFF, DIV_LAT);
        run_check("div_z",     OP_DIV,   32'hFFFF_FFF9, 32'h0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, DIV_LAT);
        run_check("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, DIV_LAT);

        // Back-to-back moves: one edge each, done pulses per move, never busy.
        bus.start   = 1'b1;
        bus.op      = OP_MTHI;
        bus.rs_data = 32'hA5A5_A5A5;
        step();
        check("mthi_hi", bus.hi, 32'hA5A5_A5A5);
        check("mthi_done", 32'(bus.done), 32'd1);
        check("mthi_busy", 32'(bus.busy), 32'd0);
        bus.op      = OP_MTLO;
        bus.rs_data = 32'h5A5A_5A5A;
        step();
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h5A5A_5A5A);
        check("mtlo_hi_kept", bus.hi, 32'hA5A5_A5A5);
        check("mtlo_done", 32'(bus.done), 32'd1);
        check("mtlo_busy", 32'(bus.busy), 32'd0);
        step();
        check("mv_done_drop", 32'(bus.done), 32'd0);

        // Reserved op and flush-with-start in idle are both ignored.
        issue(OP_RSVD, 32'h1111_1111, 32'h2222_2222);
        check("rsvd_busy", 32'(bus.busy), 32'd0);
        check("rsvd_done", 32'(bus.done), 32'd0);
        bus.flush = 1'b1;
        issue(OP_MTHI, 32'hFFFF_0000, 32'h0);
        check("idle_flush_mthi_hi", bus.hi, 32'hA5A5_A5A5);
        check("idle_flush_mthi_done", 32'(bus.done), 32'd0);
        issue(OP_MULTU, 32'd5, 32'd6);
        bus.flush = 1'b0;
        check("idle_flush_mul_busy", 32'(bus.busy), 32'd0);

        // Start held while busy is not queued; start on the done cycle is accepted.
        issue(OP_DIVU, 32'd100, 32'd7);
        bus.start   = 1'b1;
        bus.op      = OP_MTHI;
        bus.rs_data = 32'hDEAD_BEEF;
        repeat (5) begin
            step();
            lat++;
        end
        bus.start = 1'b0;
        wait_done();
        check("held_start_lat", 32'(lat), 32'(DIV_LAT));
        check("held_start_hi", bus.hi, 32'd2);
        check("held_start_lo", bus.lo, 32'd14);
        bus.start   = 1'b1;
        bus.op      = OP_MTLO;
        bus.rs_data = 32'h1111_1111;
        step();
        bus.start = 1'b0;
        check("done_start_lo", bus.lo, 32'h1111_1111);
        check("done_start_done", 32'(bus.done), 32'd1);
        issue(OP_MTHI, 32'hCAFE_F00D, 32'h0);
        check("pre_flush_hi", bus.hi, 32'hCAFE_F00D);

        // Flush at busy cycle 10: no done and HI/LO keep their prior values.
        issue(OP_MULT, 32'd5, 32'd6);
        repeat (9) step();
        check("flush_pre_busy", 32'(bus.busy), 32'd1);
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
            step();
        end
        check("flush_quiet", 32'(dcnt), 32'd0);
        check("flush_hi", bus.hi, 32'hCAFE_F00D);
        check("flush_lo", bus.lo, 32'h1111_1111);

        // Reset at busy cycle 10 clears everything.
        issue(OP_DIVU, 32'd100, 32'd7);
        repeat (9) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_hi", bus.hi, 32'h0);
        check("midrst_lo", bus.lo, 32'h0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_done", 32'(bus.done), 32'd0);
        dcnt = 0;
        repeat (40) begin
            if (bus.done === 1'b1 || bus.busy === 1'b1) dcnt++;
            step();
        end
        check("midrst_quiet", 32'(dcnt), 32'd0);

        // Unit still works after the abort.
        run_check("post_rst_mul", OP_MULTU, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0, MUL_LAT);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/mdu_iterative.md
Name: mdu_iterative

Overview:
- Multi-cycle multiply/divide responder hanging off the EX stage; owns the architectural HI/LO registers.
- EX issues a request (start + op + operands); the unit returns `busy` for pipeline stall and pulses `done` when HI/LO are updated.
- Serves MULT/MULTU/DIV/DIVU/MTHI/MTLO; MFHI/MFLO read the `hi`/`lo` outputs combinationally through the existing EX result mux.

Parameters:
- XLEN, 32, operand and HI/LO width. Only 32 is supported.
- CNT_W, 6, iteration counter width. Must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request strobe from EX. Sampled only when the unit is idle.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 reserved.
- rs_data  input  32  operand A (multiplicand/dividend/move source).
- rt_data  input  32  operand B (multiplier/divisor).
- flush  input  1  abort the in-flight operation (exception or branch squash).
- busy  output  1  high while an iterative operation is in flight. EX stalls on `busy`.
- done  output  1  one-cycle pulse on the cycle HI/LO take the new result.
- hi  output  32  architectural HI register.
- lo  output  32  architectural LO register.

Behaviour:
- Reset (`rst` = 1 at a clock edge):
  - hi = 0, lo = 0, busy = 0, done = 0.
  - FSM returns to IDLE; counter and working registers are cleared.
  - Reset wins over every other input, including a mid-operation reset.
- FSM states: IDLE, MUL, DIV, FIX.
- IDLE, `start` = 1 (flush = 0):
  - MTHI/MTLO: hi (or lo) <= rs_data at the edge, and done pulses the next cycle. busy stays 0. Single cycle.
  - MULT/MULTU: latch operands. For MULT, take absolute values and record the sign = rs[31]^rt[31]. Counter = 0, go to MUL, busy = 1 from the next cycle.
  - DIV/DIVU: latch operands. For DIV, take absolute values; record qsign = rs[31]^rt[31] and rsign = rs[31]. Go to DIV.
  - Reserved op: ignored; no state change.
- MUL:
  - Radix-2 shift-add, one multiplier bit per cycle, 32 cycles.
  - 64-bit product accumulator.
  - After counter reaches 31, go to FIX.
- DIV:
  - Restoring division, one quotient bit per cycle, 32 cycles.
  - 33-bit partial remainder.
  - After 32 iterations, go to FIX.
- FIX (1 cycle):
  - Apply sign correction (two's-complement negate of product/quotient/remainder as recorded).
  - Write hi/lo: multiply gives hi = product[63:32], lo = product[31:0]; divide gives lo = quotient, hi = remainder.
  - done = 1 for this cycle's edge output; busy drops; return to IDLE.
- Latency:
  - MUL/DIV: start accepted at edge N, done high in cycle N+34, busy high in cycles N+1..N+33.
  - HI/LO are visible the same cycle done is high.
- Boundary cases:
  - Divide by zero, both DIV and DIVU: lo = 0xFFFFFFFF, hi = rs_data (dividend unchanged). Latency is unchanged.
  - DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
  - Remainder sign always follows the dividend; quotient truncates toward zero.
- Flush:
  - While busy: return to IDLE next edge, busy = 0, no done, hi/lo unchanged.
  - In IDLE, together with start: the request is ignored (including MTHI/MTLO).
- `start` while busy: ignored. EX is stalled, so it holds the request; the unit does not queue it.
- done and start in the same cycle: the new request is accepted, because the FSM is in IDLE on that edge.

Optional Feature:
- MDU_FAST_MUL_EN defined: MULT/MULTU use a single-cycle combinational 32x32 multiply. Start at edge N → FIX → done in cycle N+2, busy high in cycle N+1 only. Divide is unchanged.
- Undefined: 32-cycle shift-add as above.
- Results are bit-identical in both builds.

Test Plan:
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → after 34 cycles done=1, hi=0xFFFFFFFE, lo=0x00000001. busy high exactly 33 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000007 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. With MDU_FAST_MUL_EN, the same values with done at cycle N+2.
- DIV 0xFFFFFFF9 (−7) / 0x00000002 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 → lo=14, hi=2.
- DIVU 0x12345678 / 0 → lo=0xFFFFFFFF, hi=0x12345678. DIV 0x80000000 / −1 → lo=0x80000000, hi=0.
- MTHI 0xA5A5A5A5 then MTLO 0x5A5A5A5A back-to-back → hi/lo updated on consecutive edges, busy never asserted, done pulses once per move.
- Issue MULT, assert flush at busy cycle 10 → busy=0 next cycle, no done, hi/lo retain prior values. Repeat with rst at cycle 10 → all outputs 0.
